uart_rx_frame: RTL

Standalone UART receiver for the far end of the tile's serial TX line: it recovers 8N1 frames from an asynchronous serial input and hands bytes to a host through a small first-word-fall-through FIFO. Its divisor semantics match the tile's transmitter: the same `dlh_dll` value on both ends gives matching baud rates. It serves as the loopback and peer partner for the TX path, with 16x oversampling, mid-bit majority voting, and sticky framing and overrun flags.

---
 rtl/uart_rx_frame_if.sv | 36 +++
 rtl/uart_rx_frame.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: host-side bus of the UART receiver.
// master = receiver, slave = host consuming bytes and status.
interface uart_rx_frame_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] rx_data_read_out;
    logic             rx_valid;
    logic             rx_full;
    logic             rx_busy;
    logic             frame_err;
    logic             overrun;
    logic             rx_data_read_en;
    logic             clr_err;

    modport master (
        output rx_data_read_out,
        output rx_valid,
        output rx_full,
        output rx_busy,
        output frame_err,
        output overrun,
        input  rx_data_read_en,
        input  clr_err
    );

    modport slave (
        input  rx_data_read_out,
        input  rx_valid,
        input  rx_full,
        input  rx_busy,
        input  frame_err,
        input  overrun,
        output rx_data_read_en,
        output clr_err
    );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with 16x oversampling, 3-sample
// majority vote, FWFT FIFO and sticky framing / overrun flags.
module uart_rx_frame #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     dlh_dll,
    input  logic            rx_data_in,
    uart_rx_frame_if.master host
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [AW:0] FULLX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state_q;
    logic           s1_q;
    logic           s2_q;
    logic           prev_q;
    logic [15:0]    pre_q;
    logic [3:0]     os_q;
    logic [1:0]     smp_q;
    logic           st_q;
    logic [WIDTH-1:0] sh_q;
    logic [BW-1:0]  nbit_q;
    logic           ferr_q;
    logic           ovr_q;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]    wp_q;
    logic [AW:0]    rp_q;
    logic [AW:0]    wp_d;
    logic [AW:0]    rp_d;

    logic fall;
    logic tick;
    logic maj;
    logic dec;
    logic wrap;
    logic stop_dec;
    logic push;
    logic ferr_set;
    logic empty;
    logic full;
    logic pop;
    logic wr;
    logic ovr_set;

    assign fall     = prev_q & ~s2_q;
    assign tick     = (pre_q >= dlh_dll);
    assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & s2_q) |
                      (smp_q[1] & s2_q);
    assign dec      = tick && (os_q == 4'd9);
    assign wrap     = tick && (os_q == 4'd15);
    assign stop_dec = (state_q == STOP) && dec;
    assign push     = stop_dec && maj;
    assign ferr_set = stop_dec && !maj;

    assign empty   = (wp_q == rp_q);
    assign full    = ((wp_q ^ rp_q) == FULLX);
    assign pop     = host.rx_data_read_en && !empty;
    assign wr      = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    // Synchronizer, prescaler, sampling and frame state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            pre_q   <= '0;
            os_q    <= '0;
            smp_q   <= '0;
            st_q    <= 1'b0;
            sh_q    <= '0;
            nbit_q  <= '0;
            state_q <= IDLE;
        end else begin
            s1_q   <= rx_data_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            if (state_q == IDLE && fall) begin
                pre_q <= '0;
                os_q  <= '0;
            end else if (tick) begin
                pre_q <= '0;
                os_q  <= os_q + 4'd1;
            end else begin
                pre_q <= pre_q + 16'd1;
            end
            if (tick && os_q == 4'd7) smp_q[0] <= s2_q;
            if (tick && os_q == 4'd8) smp_q[1] <= s2_q;
            unique case (state_q)
                IDLE: begin
                    if (fall) begin
                        nbit_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (dec) st_q <= maj;
                    if (wrap) state_q <= st_q ? IDLE : DATA;
                end
                DATA: begin
                    if (dec) begin
                        sh_q   <= {maj, sh_q[WIDTH-1:1]};
                        nbit_q <= nbit_q + 1'b1;
                    end
                    if (wrap && nbit_q == BW'(WIDTH)) state_q <= STOP;
                end
                STOP: begin
                    // Leave right after the mid-bit decision so the
                    // next start edge lands while we are in IDLE.
                    if (dec) state_q <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new event wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (ferr_set)          ferr_q <= 1'b1;
            else if (host.clr_err) ferr_q <= 1'b0;
            if (ovr_set)           ovr_q <= 1'b1;
            else if (host.clr_err) ovr_q <= 1'b0;
        end
    end

    // Next FIFO pointers.
    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (wr)  wp_d = wp_q + 1'b1;
        if (pop) rp_d = rp_q + 1'b1;
    end

    // FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // FIFO storage; contents are masked by the empty check.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q[AW-1:0]] <= sh_q;
    end

    assign host.rx_data_read_out = empty ? '0 : mem_q[rp_q[AW-1:0]];
    assign host.rx_valid         = !empty;
    assign host.rx_full          = full;
    assign host.rx_busy          = (state_q != IDLE);
    assign host.frame_err        = ferr_q;
    assign host.overrun          = ovr_q;
endmodule
